// File: rtl/receiver_fsm.sv
// Serial frame receiver: 2-flop rx synchroniser, mid-bit sampling FSM and an
// 8-cell byte matrix (2 rows x 4 cols) with a registered bit-wise read port.
//
// state | meaning
// IDLE  | line idle, waiting for rxs low
// START | timing half a bit to re-check the start bit
// DATA  | sampling 8 data bits, LSB first, once per bit period
// STOP  | waiting for the mid-stop sample
// ERR   | stop bit was 0; hold until the line returns high
module receiver_fsm #(
  parameter int BIT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  input  logic clear,
  input  logic row,
  input  logic col0,
  input  logic col1,
  output logic cell0,
  output logic cell1,
  output logic cell2,
  output logic cell3,
  output logic cell4,
  output logic cell5,
  output logic cell6,
  output logic cell7,
  output logic busy,
  output logic valid,
  output logic frame_err,
  output logic overrun,
  output logic full
);

  localparam int CW = $clog2(BIT_CYCLES);
  localparam logic [CW-1:0] CNT_HALF = CW'(BIT_CYCLES / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(BIT_CYCLES - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_ERR   = 3'd4;

  logic          rx_s1;
  logic          rx_s2;
  logic          rxs;
  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    bidx;
  logic [7:0]    shreg;
  logic [7:0]    mem [8];
  logic [3:0]    wptr;
  logic [7:0]    cell_q;
  logic [2:0]    rd_idx;
  logic          stop_hit;
  logic          good_stop;
  logic          bad_stop;

  // Synchroniser resets to the idle line level so reset never looks like a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
    end
  end

  assign rxs = rx_s2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      bidx  <= 3'd0;
      shreg <= 8'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!rxs) begin
            state <= S_START;
            cnt   <= '0;
          end
        end
        S_START: begin
          if (cnt == CNT_HALF) begin
            cnt <= '0;
            if (rxs) begin
              state <= S_IDLE;
            end else begin
              state <= S_DATA;
              bidx  <= 3'd0;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_DATA: begin
          if (cnt == CNT_LAST) begin
            shreg[bidx] <= rxs;
            cnt         <= '0;
            if (bidx == 3'd7) begin
              state <= S_STOP;
            end else begin
              bidx <= bidx + 3'd1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_STOP: begin
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            state <= rxs ? S_IDLE : S_ERR;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_ERR: begin
          if (rxs) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign stop_hit  = (state == S_STOP) && (cnt == CNT_LAST);
  assign good_stop = stop_hit && rxs;
  assign bad_stop  = stop_hit && !rxs;
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid     <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      valid     <= good_stop && !full;
      overrun   <= good_stop && full;
      frame_err <= bad_stop;
    end
  end

  // Clear takes priority over a coincident write; the valid pulse above is unaffected.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        mem[i] <= 8'd0;
      end
      wptr <= 4'd0;
      full <= 1'b0;
    end else if (clear) begin
      for (int i = 0; i < 8; i++) begin
        mem[i] <= 8'd0;
      end
      wptr <= 4'd0;
      full <= 1'b0;
    end else if (good_stop && !full) begin
      mem[wptr[2:0]] <= shreg;
      wptr           <= wptr + 4'd1;
      if (wptr == 4'd7) begin
        full <= 1'b1;
      end
    end
  end

  assign rd_idx = {row, col1, col0};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cell_q <= 8'd0;
    end else begin
      cell_q <= mem[rd_idx];
    end
  end

  assign cell0 = cell_q[0];
  assign cell1 = cell_q[1];
  assign cell2 = cell_q[2];
  assign cell3 = cell_q[3];
  assign cell4 = cell_q[4];
  assign cell5 = cell_q[5];
  assign cell6 = cell_q[6];
  assign cell7 = cell_q[7];

endmodule
